hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination/source tags of instructions in EX, MEM and WB. It drives the 2-bit selects of the two EX-stage operand 3:1 muxes (forwarding), the PC/IF-ID hold, the ID/EX bubble and the IF/ID flush. It sits beside the ID/EX pipeline register and feeds the operand muxes directly.

## Interface
- REG_ADDR_W, 5, register-index width
- CNT_W, 32, width of performance counters

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  source indices of ID instruction
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  REG_ADDR_W  destination index of ID instruction
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; whole pipe freezes
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux select: 00 regfile, 01 MEM-stage ALU result, 10 WB result
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  squash IF/ID contents
- stall_cnt, flush_cnt  out  CNT_W  load-use stall cycles / redirect flushes since reset

## Operation
- Internal slots: EX {valid, rs1, rs2, use1, use2, rd, regwrite, is_load}, MEM {valid, rd, regwrite, is_load}, WB {valid, rd, regwrite}.
- load_use = id_valid & EX.valid & EX.is_load & EX.regwrite & EX.rd≠0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Per-cycle action, priority highest first:
  - mem_busy: all slots hold; stall_if_id=1, bubble_ex=0, flush_if_id=0; counters hold.
  - ex_redirect: EX←invalid, MEM←EX, WB←MEM; flush_if_id=1, bubble_ex=1, stall_if_id=0; flush_cnt+1.
  - load_use: EX←invalid, MEM←EX, WB←MEM; stall_if_id=1, bubble_ex=1; stall_cnt+1.
  - otherwise: EX←ID fields (valid=id_valid), MEM←EX, WB←MEM; all control outputs 0.
- Forwarding, operand A. Operand B is identical with rs2/use2.
  - 01 if EX.valid & EX.use1 & MEM.valid & MEM.regwrite & MEM.rd≠0 & MEM.rd==EX.rs1.
  - else 10 if the same test holds against WB.
  - else 00.
  - MEM match beats WB match (youngest producer wins). x0 is never forwarded.
- A MEM-slot load matching an EX source is unreachable because load_use inserts a bubble. The bench asserts this never occurs.
- Counters wrap modulo 2^CNT_W.

## Timing
- fwd_*_sel are functions of registered slot state only and are valid from the start of each cycle.
- stall_if_id, bubble_ex and flush_if_id are combinational from the ID inputs, ex_redirect, mem_busy and slot state. They are valid within the same cycle and sampled by the pipeline at the next edge.
- Load-use costs exactly one bubble. The consumer reaches EX one cycle late with fwd_sel=10 from WB.
- ex_redirect together with load_use: the redirect wins, and no stall_cnt increment occurs.
- mem_busy together with ex_redirect: the freeze wins. The redirect is acted on in the first non-busy cycle, with ex_redirect still held by the EX stage.
- rst (sync): all slots invalid and both counters 0 at the next edge. Tracked instructions are discarded mid-flight.
  - After reset: fwd_*_sel=00, bubble_ex=0, flush_if_id=0, stall_if_id=mem_busy.

## Structure
- Shared core package: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, the REG_ADDR_W default, and the slot field layouts.
- One sub-module, fwd_pick: given a source index/use bit plus the MEM and WB tags, returns the 2-bit select. It is instantiated twice (A, B).

## Test plan
- Back-to-back ALU ops: add x5 then sub x6,x5,x1 → fwd_a_sel=01 for sub in EX. Next instr using x5 → 10.
- lw x7 then add x8,x7,x7 → stall_if_id=1 and bubble_ex=1 for one cycle, stall_cnt=1. add in EX gets fwd_a_sel=fwd_b_sel=10.
- Producer writing x0 followed by reader of x0 → fwd sels stay 00, no stall.
- ex_redirect in the same cycle as a load-use condition → flush_if_id=1, bubble_ex=1, stall_if_id=0, flush_cnt=1, stall_cnt=0.
- mem_busy high 3 cycles during a pending MEM→EX forward → slots frozen, fwd_a_sel stays 01, stall_if_id=1 throughout, counters unchanged.
- rst asserted with all slots valid → next cycle all fwd sels 00, counters 0, no stall with mem_busy=0.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// forwarding mux codes, register index type and tracked slot layouts.
package hazard_fwd_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     use1;
    logic     use2;
    reg_idx_t rd;
    logic     regwrite;
    logic     is_load;
  } ex_slot_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
    logic     is_load;
  } mem_slot_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regwrite;
  } wb_slot_t;

  function automatic mem_slot_t to_mem(ex_slot_t s);
    mem_slot_t m;
    m.valid    = s.valid;
    m.rd       = s.rd;
    m.regwrite = s.regwrite;
    m.is_load  = s.is_load;
    return m;
  endfunction

  function automatic wb_slot_t to_wb(mem_slot_t s);
    wb_slot_t w;
    w.valid    = s.valid;
    w.rd       = s.rd;
    w.regwrite = s.regwrite;
    return w;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage tags, pipeline control inputs and the hazard/forwarding
// outputs bundled between the core datapath and the hazard unit.
interface hazard_fwd_unit_if
  import hazard_fwd_unit_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             id_valid;
  reg_idx_t         id_rs1;
  reg_idx_t         id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  reg_idx_t         id_rd;
  logic             id_regwrite;
  logic             id_is_load;
  logic             ex_redirect;
  logic             mem_busy;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall_if_id;
  logic             bubble_ex;
  logic             flush_if_id;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_rd, id_regwrite, id_is_load,
    output ex_redirect, mem_busy,
    input  fwd_a_sel, fwd_b_sel,
    input  stall_if_id, bubble_ex, flush_if_id,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_rd, id_regwrite, id_is_load,
    input  ex_redirect, mem_busy,
    output fwd_a_sel, fwd_b_sel,
    output stall_if_id, bubble_ex, flush_if_id,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_pick.sv
// Operand forwarding select for one EX source: the youngest valid
// producer (MEM before WB) wins, and x0 is never forwarded.
module fwd_pick
  import hazard_fwd_unit_pkg::*;
(
  input  logic      ex_valid,
  input  logic      use_src,
  input  reg_idx_t  src,
  input  logic      mem_valid,
  input  logic      mem_regwrite,
  input  reg_idx_t  mem_rd,
  input  wb_slot_t  wb,
  output logic [1:0] sel
);

  logic need;
  logic hit_mem;
  logic hit_wb;

  // Match the EX source against each older producer tag.
  always_comb begin
    need    = ex_valid & use_src;
    hit_mem = need & mem_valid & mem_regwrite
            & (mem_rd != '0) & (mem_rd == src);
    hit_wb  = need & wb.valid & wb.regwrite
            & (wb.rd != '0) & (wb.rd == src);
  end

  // Prioritised select, MEM match over WB match.
  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      hit_mem:           sel = FWD_MEM;
      hit_wb & ~hit_mem: sel = FWD_WB;
      default:           sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard controller for the 5-stage core: tracks EX/MEM/WB tags,
// drives operand forwarding, load-use stall, redirect flush, counters.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  hazard_fwd_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_slot_t         ex_q, ex_d;
  mem_slot_t        mem_q, mem_d;
  wb_slot_t         wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ex_slot_t id_slot;
  logic     load_use;
  logic     act_freeze;
  logic     act_redir;
  logic     act_lu;
  logic     stall;
  logic     bubble;
  logic     flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic     unused_mem_load;

  assign unused_mem_load = mem_q.is_load;

  // Capture the ID instruction tags and detect a load-use hazard.
  always_comb begin
    id_slot.valid    = bus.id_valid;
    id_slot.rs1      = bus.id_rs1;
    id_slot.rs2      = bus.id_rs2;
    id_slot.use1     = bus.id_use_rs1;
    id_slot.use2     = bus.id_use_rs2;
    id_slot.rd       = bus.id_rd;
    id_slot.regwrite = bus.id_regwrite;
    id_slot.is_load  = bus.id_is_load;
    load_use = bus.id_valid & ex_q.valid & ex_q.is_load
             & ex_q.regwrite & (ex_q.rd != '0)
             & ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd))
              | (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));
    act_freeze = bus.mem_busy;
    act_redir  = ~bus.mem_busy & bus.ex_redirect;
    act_lu     = ~bus.mem_busy & ~bus.ex_redirect & load_use;
  end

  // Next slot state, counters and pipeline control, by priority.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    unique case (1'b1)
      act_freeze: begin
        stall = 1'b1;
      end
      act_redir: begin
        ex_d        = '0;
        mem_d       = to_mem(ex_q);
        wb_d        = to_wb(mem_q);
        flush       = 1'b1;
        bubble      = 1'b1;
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      act_lu: begin
        ex_d        = '0;
        mem_d       = to_mem(ex_q);
        wb_d        = to_wb(mem_q);
        stall       = 1'b1;
        bubble      = 1'b1;
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      default: begin
        ex_d  = id_slot;
        mem_d = to_mem(ex_q);
        wb_d  = to_wb(mem_q);
      end
    endcase
    if (rst) begin
      ex_d        = '0;
      mem_d       = '0;
      wb_d        = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  // Slot and counter registers.
  always_ff @(posedge clk) begin
    ex_q        <= ex_d;
    mem_q       <= mem_d;
    wb_q        <= wb_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  fwd_pick u_pick_a (
    .ex_valid     (ex_q.valid),
    .use_src      (ex_q.use1),
    .src          (ex_q.rs1),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb           (wb_q),
    .sel          (sel_a)
  );

  fwd_pick u_pick_b (
    .ex_valid     (ex_q.valid),
    .use_src      (ex_q.use2),
    .src          (ex_q.rs2),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb           (wb_q),
    .sel          (sel_b)
  );

  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall_if_id = stall;
  assign bus.bubble_ex   = bubble;
  assign bus.flush_if_id = flush;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Vector table + scoreboard bench for the hazard/forwarding unit.
// Expected outputs are hand-derived per cycle of the instruction stream.
module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  typedef struct packed {
    logic     v;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     u1;
    logic     u2;
    reg_idx_t rd;
    logic     rw;
    logic     ld;
  } ins_t;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  typedef struct {
    logic [2:0] drv;
    ins_t       ins;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;
  vec_t tbl[$];
  exp_t exp_q[$];

  hazard_fwd_unit_if #(.CNT_W(32)) bus ();

  hazard_fwd_unit #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    return i;
  endfunction

  function automatic ins_t alu(int rd, int a, int b);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
    i.rd = reg_idx_t'(rd); i.rs1 = reg_idx_t'(a); i.rs2 = reg_idx_t'(b);
    return i;
  endfunction

  function automatic ins_t alui(int rd, int a);
    ins_t i;
    i = alu(rd, a, 0);
    i.u2 = 1'b0;
    return i;
  endfunction

  function automatic ins_t lw(int rd, int a);
    ins_t i;
    i = alui(rd, a);
    i.ld = 1'b1;
    return i;
  endfunction

  // drv = {rst, mem_busy, ex_redirect}; ctl = {stall, bubble, flush}
  function automatic vec_t mkv(logic [2:0] drv, ins_t ins,
                               logic [1:0] fa, logic [1:0] fb,
                               logic [2:0] ctl, int sc, int fc);
    vec_t v;
    v.drv = drv; v.ins = ins;
    v.e.fa = fa; v.e.fb = fb; v.e.ctl = ctl;
    v.e.sc = 32'(sc); v.e.fc = 32'(fc);
    return v;
  endfunction

  task automatic cmp(string tag, string nm,
                     logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", tag, nm, act, req);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    exp_t e;
    @(negedge clk);
    rst             = v.drv[2];
    bus.mem_busy    = v.drv[1];
    bus.ex_redirect = v.drv[0];
    bus.id_valid    = v.ins.v;
    bus.id_rs1      = v.ins.rs1;
    bus.id_rs2      = v.ins.rs2;
    bus.id_use_rs1  = v.ins.u1;
    bus.id_use_rs2  = v.ins.u2;
    bus.id_rd       = v.ins.rd;
    bus.id_regwrite = v.ins.rw;
    bus.id_is_load  = v.ins.ld;
    exp_q.push_back(v.e);
    #2;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty want entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "fwd_a", 32'(bus.fwd_a_sel), 32'(e.fa));
      cmp(tag, "fwd_b", 32'(bus.fwd_b_sel), 32'(e.fb));
      cmp(tag, "stall", 32'(bus.stall_if_id), 32'(e.ctl[2]));
      cmp(tag, "bubble", 32'(bus.bubble_ex), 32'(e.ctl[1]));
      cmp(tag, "flush", 32'(bus.flush_if_id), 32'(e.ctl[0]));
      cmp(tag, "stall_cnt", bus.stall_cnt, e.sc);
      cmp(tag, "flush_cnt", bus.flush_cnt, e.fc);
    end
  endtask

  // A load sitting in MEM must never feed an EX source directly.
  always @(negedge clk) begin
    if (chk_on && dut.ex_q.valid === 1'b1 && dut.mem_q.valid === 1'b1
        && dut.mem_q.is_load === 1'b1 && dut.mem_q.regwrite === 1'b1
        && dut.mem_q.rd != '0
        && ((dut.ex_q.use1 === 1'b1 && dut.ex_q.rs1 == dut.mem_q.rd)
         || (dut.ex_q.use2 === 1'b1 && dut.ex_q.rs2 == dut.mem_q.rd))) begin
      checks++;
      errors++;
      $display("FAIL mem_load_fwd: got load in MEM feeding EX want none");
    end
  end

  initial begin
    rst = 1'b1;
    bus.mem_busy = 1'b0; bus.ex_redirect = 1'b0;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.id_is_load = 1'b0;
    repeat (2) @(posedge clk);

    tbl.push_back(mkv(3'b000, nop(),           0, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, alu(5, 1, 2),    0, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, alu(6, 5, 1),    0, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, alu(9, 5, 3),    1, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, nop(),           2, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, lw(7, 1),        0, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b000, alu(8, 7, 7),    0, 0, 3'b110, 0, 0));
    tbl.push_back(mkv(3'b000, alu(8, 7, 7),    0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, nop(),           2, 2, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, alui(0, 1),      0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, alu(10, 0, 0),   0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, nop(),           0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, lw(0, 2),        0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, alu(11, 0, 0),   0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, nop(),           0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b000, lw(12, 1),       0, 0, 3'b000, 1, 0));
    tbl.push_back(mkv(3'b001, alu(13, 12, 0),  0, 0, 3'b011, 1, 0));
    tbl.push_back(mkv(3'b000, nop(),           0, 0, 3'b000, 1, 1));
    tbl.push_back(mkv(3'b000, alu(14, 1, 2),   0, 0, 3'b000, 1, 1));
    tbl.push_back(mkv(3'b000, alu(15, 14, 3),  0, 0, 3'b000, 1, 1));
    tbl.push_back(mkv(3'b010, alu(16, 1, 1),   1, 0, 3'b100, 1, 1));
    tbl.push_back(mkv(3'b010, alu(16, 1, 1),   1, 0, 3'b100, 1, 1));
    tbl.push_back(mkv(3'b011, alu(16, 1, 1),   1, 0, 3'b100, 1, 1));
    tbl.push_back(mkv(3'b001, alu(16, 1, 1),   1, 0, 3'b011, 1, 1));
    tbl.push_back(mkv(3'b000, alu(20, 1, 2),   0, 0, 3'b000, 1, 2));
    tbl.push_back(mkv(3'b000, alu(17, 1, 2),   0, 0, 3'b000, 1, 2));
    tbl.push_back(mkv(3'b000, alu(18, 17, 17), 0, 0, 3'b000, 1, 2));
    tbl.push_back(mkv(3'b100, alu(19, 18, 17), 1, 1, 3'b000, 1, 2));
    tbl.push_back(mkv(3'b000, alu(21, 18, 17), 0, 0, 3'b000, 0, 0));
    tbl.push_back(mkv(3'b010, nop(),           0, 0, 3'b100, 0, 0));
    tbl.push_back(mkv(3'b000, nop(),           0, 0, 3'b000, 0, 0));

    chk_on = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Repeated load-use pairs: one bubble each, counter steps by one.
    for (int k = 0; k < 3; k++) begin
      apply(mkv(3'b000, lw(7, 1),     0, 0, 3'b000, k, 0),
            $sformatf("lu%0d_load", k));
      apply(mkv(3'b000, alu(8, 7, 7), 0, 0, 3'b110, k, 0),
            $sformatf("lu%0d_stall", k));
      apply(mkv(3'b000, alu(8, 7, 7), 0, 0, 3'b000, k + 1, 0),
            $sformatf("lu%0d_held", k));
      apply(mkv(3'b000, nop(),        2, 2, 3'b000, k + 1, 0),
            $sformatf("lu%0d_fwd", k));
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
